wb_stage: RTL and testbench

- Write-back stage of the 5-stage pipeline.
- Selects the value written back to the register file: the memory read data for loads, or the ALU result / address (`dir`) for everything else.
- `data_out` is the combinational select result, used by forwarding and debug.
- A registered register-file write port (`rf_*`) presents the committed write to the register file one cycle later.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_load_align.sv | 32 +++
 rtl/wb_stage.sv | 72 +++++++
 tb/tb_wb_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage: default widths, mem_size encodings,
// and the hard-wired zero register index.
package wb_pkg;

  localparam int unsigned DEFAULT_DATA_W     = 32;
  localparam int unsigned DEFAULT_REG_ADDR_W = 5;

  // mem_size encodings; 2'b11 is reserved and handled as a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_load_align.sv
// Little-endian sub-word extraction from load data with sign/zero extension.
// Purely combinational; only instantiated when WB_LOAD_EXT_EN is defined.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_i[{offset_i, 3'b000} +: 8];
    // Half-word accesses ignore offset bit 0.
    half_sel = data_i[{offset_i[1], 4'b0000} +: 16];
    load_o   = data_i;
    case (size_i)
      SZ_BYTE: load_o = unsigned_i ? DATA_W'(byte_sel)
                                   : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = unsigned_i ? DATA_W'(half_sel)
                                   : {{(DATA_W-16){half_sel[15]}}, half_sel};
      default: load_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: combinational load/ALU select plus a registered register-file write port.
// Optional sub-word load extraction is enabled by defining WB_LOAD_EXT_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_to_reg,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W-1:0]     dir,
  input  logic                  valid_in,
  input  logic                  reg_write_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
`ifdef WB_LOAD_EXT_EN
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
`endif
  output logic [DATA_W-1:0]     data_out,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata
);

  logic [DATA_W-1:0] load_value;

`ifdef WB_LOAD_EXT_EN
  wb_load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .data_i    (data_in),
    .offset_i  (dir[1:0]),
    .size_i    (mem_size),
    .unsigned_i(mem_unsigned),
    .load_o    (load_value)
  );
`else
  assign load_value = data_in;
`endif

  assign data_out = mem_to_reg ? load_value : dir;

  logic                  rf_we_d,    rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_d, rf_waddr_q;
  logic [DATA_W-1:0]     rf_wdata_d, rf_wdata_q;

  // Address and data capture unconditionally; only the enable is qualified.
  always_comb begin
    rf_we_d    = valid_in & reg_write_in & (rd_in != REG_ADDR_W'(REG_ZERO));
    rf_waddr_d = rd_in;
    rf_wdata_d = data_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic against a
// behavioural model of the select, load extraction and registered write port.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_to_reg;
  logic [31:0] data_in;
  logic [31:0] dir;
  logic        valid_in;
  logic        reg_write_in;
  logic [4:0]  rd_in;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] data_out;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(
    .DATA_W    (32),
    .REG_ADDR_W(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_to_reg  (mem_to_reg),
    .data_in     (data_in),
    .dir         (dir),
    .valid_in    (valid_in),
    .reg_write_in(reg_write_in),
    .rd_in       (rd_in),
`ifdef WB_LOAD_EXT_EN
    .mem_size    (mem_size),
    .mem_unsigned(mem_unsigned),
`endif
    .data_out    (data_out),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: pick load value by byte shifting and masking, then choose against dir.
  function automatic logic [31:0] model_dout(input logic m2r, input logic [31:0] din,
                                             input logic [31:0] d, input logic [1:0] sz,
                                             input logic uns);
    logic [31:0] lv;
    lv = din;
`ifdef WB_LOAD_EXT_EN
    begin
      int nbits;
      int shift;
      logic [31:0] mask;
      nbits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
      shift = (sz == 2'b01) ? 16 * int'(d[1]) : 8 * int'(d[1:0]);
      if (nbits < 32) begin
        mask = (32'd1 << nbits) - 32'd1;
        lv   = (din >> shift) & mask;
        if (!uns && lv[nbits-1]) lv = lv | ~mask;
      end
    end
`endif
    return m2r ? lv : d;
  endfunction

  task automatic check_dout(input string tag);
    #1;
    check_eq(tag, data_out, model_dout(mem_to_reg, data_in, dir, mem_size, mem_unsigned));
  endtask

  // Drive one instruction between edges, then check the registered port after the edge.
  task automatic cycle(input string tag, input logic v, input logic w, input logic [4:0] rd,
                       input logic m2r, input logic [31:0] din, input logic [31:0] d);
    logic        exp_we;
    logic [31:0] exp_wd;
    @(negedge clk);
    valid_in     = v;
    reg_write_in = w;
    rd_in        = rd;
    mem_to_reg   = m2r;
    data_in      = din;
    dir          = d;
    exp_we = v && w && (rd != 5'd0);
    exp_wd = model_dout(m2r, din, d, mem_size, mem_unsigned);
    @(posedge clk);
    #1;
    check_eq({tag, "_we"}, {31'd0, rf_we}, {31'd0, exp_we});
    check_eq({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, rd});
    check_eq({tag, "_wdata"}, rf_wdata, exp_wd);
  endtask

  initial begin
    rst          = 1'b1;
    mem_to_reg   = 1'b0;
    data_in      = '0;
    dir          = '0;
    valid_in     = 1'b0;
    reg_write_in = 1'b0;
    rd_in        = '0;
    mem_size     = 2'b10;
    mem_unsigned = 1'b0;

    #2;
    check_eq("reset_we", {31'd0, rf_we}, 32'd0);
    check_eq("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    check_eq("reset_wdata", rf_wdata, 32'd0);

    @(negedge clk);
    rst = 1'b0;

    // Combinational select, no clock edge between changes.
    data_in = 32'hAAAA_AAAA; dir = 32'h0000_0001;
    #1; check_eq("sel_dir", data_out, 32'h0000_0001);
    mem_to_reg = 1'b1;
    #1; check_eq("sel_mem", data_out, 32'hAAAA_AAAA);
    data_in = 32'h0000_FFFF;
    #1; check_eq("sel_mem_track", data_out, 32'h0000_FFFF);
    mem_to_reg = 1'b0;
    #1; check_eq("sel_back_dir", data_out, 32'h0000_0001);
    dir = 32'hFFFF_FFFF;
    #1; check_eq("sel_dir_track", data_out, 32'hFFFF_FFFF);

    // Registered write port.
    cycle("wr_r5", 1'b1, 1'b1, 5'd5, 1'b1, 32'h1234_5678, 32'h0);
    check_eq("wr_r5_abs", rf_wdata, 32'h1234_5678);
    cycle("wr_r0", 1'b1, 1'b1, 5'd0, 1'b1, 32'h1234_5678, 32'h0);
    cycle("bubble", 1'b0, 1'b1, 5'd5, 1'b1, 32'h1234_5678, 32'h0);
    cycle("no_wr", 1'b1, 1'b0, 5'd7, 1'b0, 32'h0, 32'hCAFE_F00C);

    // Asynchronous reset between edges.
    cycle("pre_rst", 1'b1, 1'b1, 5'd9, 1'b0, 32'h0, 32'hDEAD_BEEC);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_we", {31'd0, rf_we}, 32'd0);
    check_eq("rst_async_waddr", {27'd0, rf_waddr}, 32'd0);
    check_eq("rst_async_wdata", rf_wdata, 32'd0);
    dir = 32'h0BAD_F00C;
    #1; check_eq("rst_dout_track", data_out, 32'h0BAD_F00C);
    @(posedge clk);
    #1;
    check_eq("rst_hold_we", {31'd0, rf_we}, 32'd0);
    check_eq("rst_hold_wdata", rf_wdata, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_we", {31'd0, rf_we}, 32'd1);
    check_eq("post_rst_waddr", {27'd0, rf_waddr}, 32'd9);
    check_eq("post_rst_wdata", rf_wdata, 32'h0BAD_F00C);

`ifdef WB_LOAD_EXT_EN
    @(negedge clk);
    data_in = 32'h80FF_7F01; mem_to_reg = 1'b1;
    dir = 32'd3; mem_size = 2'b00; mem_unsigned = 1'b0;
    #1; check_eq("ext_b3_s", data_out, 32'hFFFF_FF80);
    dir = 32'd2; mem_size = 2'b01; mem_unsigned = 1'b1;
    #1; check_eq("ext_h2_u", data_out, 32'h0000_80FF);
    dir = 32'd0; mem_size = 2'b00; mem_unsigned = 1'b1;
    #1; check_eq("ext_b0_u", data_out, 32'h0000_0001);
    data_in = 32'h0000_FFFF; dir = 32'd1; mem_unsigned = 1'b0;
    #1; check_eq("ext_b1_s", data_out, 32'hFFFF_FFFF);
    mem_size = 2'b11;
    #1; check_eq("ext_rsvd_word", data_out, 32'h0000_FFFF);
`endif

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
`ifdef WB_LOAD_EXT_EN
      mem_size     = 2'($urandom_range(0, 3));
      mem_unsigned = 1'($urandom_range(0, 1));
`endif
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      check_dout("rand_dout");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
